skip_adder_sequencer: RTL

SKIP_ADDER_SEQUENCER -- requirements
Module: skip_adder_sequencer

---
 rtl/skip_adder_pkg.sv | 14 +
 rtl/csa_slice4.sv | 37 +++
 rtl/skip_adder_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/skip_adder_pkg.sv
// Shared types and constants for the skip-adder sequencer.
//   SLICE_W : width of the slice processed each cycle
//   state_e : sequencer FSM states
package skip_adder_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/csa_slice4.sv
// Combinational 4-bit ripple adder with a carry-skip bypass.
// Ports:
//   a4, b4 : slice operands
//   cin4   : slice carry-in
//   sum4   : slice sum
//   cout4  : slice carry-out (bypassed from cin4 when every bit propagates)
//   skip   : high when the bypass path supplies cout4
module csa_slice4
   import skip_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a4,
   input  logic [SLICE_W-1:0] b4,
   input  logic               cin4,
   output logic [SLICE_W-1:0] sum4,
   output logic               cout4,
   output logic               skip
);

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W:0]   c;

   always_comb begin
      p    = a4 ^ b4;
      g    = a4 & b4;
      c    = '0;
      c[0] = cin4;
      for (int i = 0; i < SLICE_W; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      sum4  = p ^ c[SLICE_W-1:0];
      skip  = &p;
      // All-propagate slice: carry-in passes straight through.
      cout4 = skip ? cin4 : c[SLICE_W];
   end

endmodule

// File: rtl/skip_adder_sequencer.sv
// Multi-cycle adder: one 4-bit carry-skip slice is reused every cycle, so a WIDTH-bit add
// takes WIDTH/4 cycles in RUN, then the result is held in DONE until out_ready.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands and carry-in
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout            : result and MSB carry-out
//   busy                 : high whenever not IDLE
//   skip_cnt             : slices that took the skip path (only with SKIP_ADDER_STATS_EN)
// Optional feature macro: SKIP_ADDER_STATS_EN.
module skip_adder_sequencer
   import skip_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SKIP_ADDER_STATS_EN
   output logic [$clog2(WIDTH/SLICE_W+1)-1:0] skip_cnt,
`endif
   output logic             busy
);

   localparam int unsigned NIB = WIDTH / SLICE_W;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               carry_q;
   logic               cout_q;
   logic [IW-1:0]      idx_q;

   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;
   logic               slice_skip;

   csa_slice4 u_slice (
      .a4    (a_q[idx_q*SLICE_W +: SLICE_W]),
      .b4    (b_q[idx_q*SLICE_W +: SLICE_W]),
      .cin4  (carry_q),
      .sum4  (slice_sum),
      .cout4 (slice_cout),
      .skip  (slice_skip)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
               carry_q <= slice_cout;
               if (idx_q == LAST_IDX) begin
                  // Counter parks on the last slice so it never exceeds NIB-1.
                  cout_q  <= slice_cout;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SKIP_ADDER_STATS_EN
   localparam int unsigned SCW = $clog2(NIB + 1);
   logic [SCW-1:0] skip_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_cnt_q <= '0;
      end else if (state_q == IDLE && in_valid) begin
         skip_cnt_q <= '0;
      end else if (state_q == RUN && slice_skip) begin
         skip_cnt_q <= skip_cnt_q + SCW'(1);
      end
   end

   assign skip_cnt = skip_cnt_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
